// File: rtl/dyt_regfile_mp_pkg.sv
// Shared types for the dyt integer register file: data word, register select
// and the hard-wired zero register index.
package common_types;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [XLEN_DEF-1:0]           word_t;
    typedef logic [$clog2(NREGS_DEF)-1:0]  reg_sel_t;

    localparam reg_sel_t REG_ZERO = '0;

endpackage

// File: rtl/dyt_regfile_mp_if.sv
// Decode/writeback-facing bus of the multi-port register file: read ports,
// write ports, scoreboard reserve/flush and the busy vector.
interface dyt_regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NRD-1:0][AW-1:0]   rd_sel;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_sel;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     rsv_en;
    logic [AW-1:0]            rsv_sel;
    logic                     flush;
    logic [NREGS-1:0]         busy_vec;

    modport master (
        output rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel, flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel, flush,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/dyt_regfile_mp_scoreboard.sv
// Pending-writeback scoreboard: one busy flop per register, set by decode
// reservations, cleared by writeback and wiped by a pipeline flush.
module dyt_rf_scoreboard
    import common_types::*;
#(
    parameter int NREGS = 32,
    parameter int NWR   = 1
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic [NWR-1:0]                   wr_en,
    input  logic [NWR-1:0][$clog2(NREGS)-1:0] wr_sel,
    input  logic                             rsv_en,
    input  logic [$clog2(NREGS)-1:0]         rsv_sel,
    input  logic                             flush,
    output logic [NREGS-1:0]                 busy_vec
);
    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Priority low to high: release, reserve (new producer wins), flush.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i]) begin
                busy_d[wr_sel[i]] = 1'b0;
            end
        end
        if (rsv_en && !flush && rsv_sel != AW'(REG_ZERO)) begin
            busy_d[rsv_sel] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/dyt_regfile_mp.sv
// Parametrised NRD-read / NWR-write integer register file with optional
// same-cycle write-to-read bypass and an integrated busy scoreboard.
module dyt_regfile_mp
    import common_types::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            n_rst,
    dyt_regfile_mp_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    typedef logic [NREGS-1:0][XLEN-1:0] rf_t;

    rf_t                      rf_q;
    logic [NREGS-1:0]         busy_vec;
    logic [NRD-1:0][XLEN-1:0] rd_data_c;
    logic [NRD-1:0]           rd_busy_c;
    logic [NRD-1:0]           rd_hit;

    dyt_rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .n_rst    (n_rst),
        .wr_en    (bus.wr_en),
        .wr_sel   (bus.wr_sel),
        .rsv_en   (bus.rsv_en),
        .rsv_sel  (bus.rsv_sel),
        .flush    (bus.flush),
        .busy_vec (busy_vec)
    );

    // Entry 0 is never written, so it stays at its reset value of zero and
    // folds away as a constant; later ports overwrite earlier ones.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rf_q <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (bus.wr_en[i] && bus.wr_sel[i] != AW'(REG_ZERO)) begin
                    rf_q[bus.wr_sel[i]] <= bus.wr_data[i];
                end
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        rd_hit    = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_data_c[k] = rf_q[bus.rd_sel[k]];
            if (BYPASS != 0) begin
                for (int i = 0; i < NWR; i++) begin
                    if (bus.wr_en[i] && bus.wr_sel[i] == bus.rd_sel[k] &&
                        bus.rd_sel[k] != AW'(REG_ZERO)) begin
                        rd_data_c[k] = bus.wr_data[i];
                        rd_hit[k]    = 1'b1;
                    end
                end
            end
            // busy_vec[0] is held low, so x0 never reports a hazard.
            rd_busy_c[k] = busy_vec[bus.rd_sel[k]] & ~rd_hit[k];
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_vec = busy_vec;

endmodule

// File: tb/tb_dyt_regfile_mp.sv
// Bench for dyt_regfile_mp: a bypassing and a non-bypassing instance share one
// stimulus stream and are compared against a register/busy array model.
module tb_dyt_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;

    logic [NRD-1:0][4:0]      rd_sel;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][4:0]      wr_sel;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     rsv_en;
    logic [4:0]               rsv_sel;
    logic                     flush;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] m_mem [NREGS] = '{default: '0};
    logic [NREGS-1:0] m_busy = '0;

    always #5 clk = ~clk;

    dyt_regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_b ();
    dyt_regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_n ();

    assign bus_b.rd_sel  = rd_sel;
    assign bus_b.wr_en   = wr_en;
    assign bus_b.wr_sel  = wr_sel;
    assign bus_b.wr_data = wr_data;
    assign bus_b.rsv_en  = rsv_en;
    assign bus_b.rsv_sel = rsv_sel;
    assign bus_b.flush   = flush;
    assign bus_n.rd_sel  = rd_sel;
    assign bus_n.wr_en   = wr_en;
    assign bus_n.wr_sel  = wr_sel;
    assign bus_n.wr_data = wr_data;
    assign bus_n.rsv_en  = rsv_en;
    assign bus_n.rsv_sel = rsv_sel;
    assign bus_n.flush   = flush;

    dyt_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_byp (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_b)
    );

    dyt_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_nob (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_n)
    );

    // Architectural model: writes land in order of port index, a reservation
    // beats a release, a flush beats everything; x0 is never touched.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < NREGS; r++) m_mem[r] <= '0;
            m_busy <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && wr_sel[i] != 0) begin
                    m_mem[wr_sel[i]]  <= wr_data[i];
                    m_busy[wr_sel[i]] <= 1'b0;
                end
            end
            if (rsv_en && rsv_sel != 0) m_busy[rsv_sel] <= 1'b1;
            if (flush) m_busy <= '0;
        end
    end

    function automatic logic [XLEN-1:0] m_rd(bit byp, logic [4:0] sel);
        if (sel == 0) return '0;
        if (byp) begin
            for (int i = NWR - 1; i >= 0; i--) begin
                if (wr_en[i] && wr_sel[i] == sel) return wr_data[i];
            end
        end
        return m_mem[sel];
    endfunction

    function automatic logic m_rdbusy(bit byp, logic [4:0] sel);
        if (sel == 0) return 1'b0;
        if (byp) begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && wr_sel[i] == sel) return 1'b0;
            end
        end
        return m_busy[sel];
    endfunction

    function automatic logic [4:0] rand_sel();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, NREGS - 1));
    endfunction

    task automatic idle();
        wr_en   = '0;
        wr_sel  = '0;
        wr_data = '0;
        rsv_en  = 1'b0;
        rsv_sel = '0;
        flush   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rd_sel = '0;
        #2;
        n_rst  = 1'b0;
        rd_sel = {5'd5, 5'd5};
        #1;
        for (int k = 0; k < NRD; k++) begin
            n_checks += 2;
            if (bus_b.rd_data[k] !== '0 || bus_n.rd_data[k] !== '0) begin
                n_fail++;
                $display("FAIL reset_rd_data[%0d]: got %h/%h expected 0", k, bus_b.rd_data[k], bus_n.rd_data[k]);
            end
            if (bus_b.rd_busy[k] !== 1'b0 || bus_n.rd_busy[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rd_busy[%0d]: got %b/%b expected 0", k, bus_b.rd_busy[k], bus_n.rd_busy[k]);
            end
        end
        n_checks++;
        if (bus_b.busy_vec !== '0 || bus_n.busy_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_busy_vec: got %h/%h expected 0", bus_b.busy_vec, bus_n.busy_vec);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        next_cycle();
        n_checks += 2;
        if (bus_b.rd_data[0] !== '0 || bus_n.rd_data[1] !== '0) begin
            n_fail++;
            $display("FAIL post_reset_rd_data: got %h/%h expected 0", bus_b.rd_data[0], bus_n.rd_data[1]);
        end
        if (bus_b.busy_vec !== '0 || bus_n.rd_busy !== '0) begin
            n_fail++;
            $display("FAIL post_reset_busy: got %h/%b expected 0", bus_b.busy_vec, bus_n.rd_busy);
        end
    endtask

    task automatic test_x0();
        idle();
        wr_en      = 2'b01;
        wr_sel[0]  = 5'd0;
        wr_data[0] = 32'hDEAD_BEEF;
        rsv_en     = 1'b1;
        rsv_sel    = 5'd0;
        rd_sel     = {5'd0, 5'd0};
        #1;
        n_checks++;
        if (bus_b.rd_data[0] !== '0 || bus_n.rd_data[0] !== '0) begin
            n_fail++;
            $display("FAIL x0_same_cycle: got %h/%h expected 0", bus_b.rd_data[0], bus_n.rd_data[0]);
        end
        next_cycle();
        idle();
        #1;
        n_checks += 2;
        if (bus_b.rd_data[1] !== '0 || bus_n.rd_data[1] !== '0) begin
            n_fail++;
            $display("FAIL x0_next_cycle: got %h/%h expected 0", bus_b.rd_data[1], bus_n.rd_data[1]);
        end
        if (bus_b.busy_vec !== '0 || bus_n.busy_vec !== '0) begin
            n_fail++;
            $display("FAIL x0_busy_vec: got %h/%h expected 0", bus_b.busy_vec, bus_n.busy_vec);
        end
        next_cycle();
    endtask

    task automatic test_bypass();
        idle();
        wr_en      = 2'b01;
        wr_sel[0]  = 5'd3;
        wr_data[0] = 32'h1234_5678;
        rd_sel     = {5'd0, 5'd3};
        #1;
        n_checks += 2;
        if (bus_b.rd_data[0] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got %h expected 12345678", bus_b.rd_data[0]);
        end
        if (bus_n.rd_data[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL nobypass_old_value: got %h expected 0", bus_n.rd_data[0]);
        end
        next_cycle();
        idle();
        #1;
        n_checks += 2;
        if (bus_b.rd_data[0] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: got %h expected 12345678", bus_b.rd_data[0]);
        end
        if (bus_n.rd_data[0] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL nobypass_next_cycle: got %h expected 12345678", bus_n.rd_data[0]);
        end
        next_cycle();
    endtask

    task automatic test_conflict();
        idle();
        wr_en   = 2'b11;
        wr_sel  = {5'd7, 5'd7};
        wr_data = {32'h2, 32'h1};
        rd_sel  = {5'd7, 5'd0};
        #1;
        n_checks++;
        if (bus_b.rd_data[1] !== 32'h2) begin
            n_fail++;
            $display("FAIL conflict_bypass: got %h expected 2", bus_b.rd_data[1]);
        end
        next_cycle();
        idle();
        #1;
        n_checks += 2;
        if (bus_b.rd_data[1] !== 32'h2) begin
            n_fail++;
            $display("FAIL conflict_stored_byp: got %h expected 2", bus_b.rd_data[1]);
        end
        if (bus_n.rd_data[1] !== 32'h2) begin
            n_fail++;
            $display("FAIL conflict_stored_nob: got %h expected 2", bus_n.rd_data[1]);
        end
        next_cycle();
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_en  = 1'b1;
        rsv_sel = 5'd9;
        rd_sel  = {5'd9, 5'd9};
        #1;
        n_checks++;
        if (bus_b.rd_busy !== 2'b00 || bus_n.rd_busy !== 2'b00 || bus_b.busy_vec !== '0) begin
            n_fail++;
            $display("FAIL sb_reserve_same_cycle: got %b/%b/%h expected 0", bus_b.rd_busy, bus_n.rd_busy, bus_b.busy_vec);
        end
        next_cycle();
        wr_en      = 2'b01;
        wr_sel[0]  = 5'd9;
        wr_data[0] = 32'h99;
        #1;
        n_checks += 3;
        if (bus_b.busy_vec !== 32'h0000_0200 || bus_n.busy_vec !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL sb_reserved: got %h/%h expected 00000200", bus_b.busy_vec, bus_n.busy_vec);
        end
        if (bus_b.rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL sb_byp_release_rd_busy: got %b expected 00", bus_b.rd_busy);
        end
        if (bus_n.rd_busy !== 2'b11) begin
            n_fail++;
            $display("FAIL sb_nob_rd_busy: got %b expected 11", bus_n.rd_busy);
        end
        next_cycle();
        idle();
        wr_en      = 2'b10;
        wr_sel[1]  = 5'd9;
        wr_data[1] = 32'h9A;
        #1;
        n_checks += 2;
        if (bus_b.busy_vec !== 32'h0000_0200 || bus_n.busy_vec !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL sb_set_wins: got %h/%h expected 00000200", bus_b.busy_vec, bus_n.busy_vec);
        end
        if (bus_b.rd_busy !== 2'b00 || bus_n.rd_busy !== 2'b11) begin
            n_fail++;
            $display("FAIL sb_release_cycle_rd_busy: got %b/%b expected 00/11", bus_b.rd_busy, bus_n.rd_busy);
        end
        next_cycle();
        idle();
        #1;
        n_checks += 2;
        if (bus_b.busy_vec !== '0 || bus_n.busy_vec !== '0 || bus_n.rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL sb_cleared: got %h/%h/%b expected 0", bus_b.busy_vec, bus_n.busy_vec, bus_n.rd_busy);
        end
        if (bus_n.rd_data[0] !== 32'h9A) begin
            n_fail++;
            $display("FAIL sb_written_data: got %h expected 0000009a", bus_n.rd_data[0]);
        end
        next_cycle();
    endtask

    task automatic test_flush();
        logic [4:0] regs [3];
        regs[0] = 5'd4;
        regs[1] = 5'd6;
        regs[2] = 5'd8;
        idle();
        for (int j = 0; j < 3; j++) begin
            rsv_en  = 1'b1;
            rsv_sel = regs[j];
            next_cycle();
        end
        idle();
        flush      = 1'b1;
        rsv_en     = 1'b1;
        rsv_sel    = 5'd10;
        wr_en      = 2'b10;
        wr_sel[1]  = 5'd12;
        wr_data[1] = 32'hCAFE_0012;
        #1;
        n_checks++;
        if (bus_b.busy_vec !== 32'h0000_0150 || bus_n.busy_vec !== 32'h0000_0150) begin
            n_fail++;
            $display("FAIL flush_before: got %h/%h expected 00000150", bus_b.busy_vec, bus_n.busy_vec);
        end
        next_cycle();
        idle();
        rd_sel = {5'd10, 5'd12};
        #1;
        n_checks += 3;
        if (bus_b.busy_vec !== '0 || bus_n.busy_vec !== '0) begin
            n_fail++;
            $display("FAIL flush_busy_vec: got %h/%h expected 0", bus_b.busy_vec, bus_n.busy_vec);
        end
        if (bus_b.rd_data[0] !== 32'hCAFE_0012 || bus_n.rd_data[0] !== 32'hCAFE_0012) begin
            n_fail++;
            $display("FAIL flush_write_kept: got %h/%h expected cafe0012", bus_b.rd_data[0], bus_n.rd_data[0]);
        end
        if (bus_n.rd_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_x10_rd_busy: got %b expected 0", bus_n.rd_busy[1]);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        idle();
        wr_en      = 2'b01;
        wr_sel[0]  = 5'd20;
        wr_data[0] = 32'hA5A5_5A5A;
        rsv_en     = 1'b1;
        rsv_sel    = 5'd21;
        next_cycle();
        wr_sel[0]  = 5'd22;
        wr_data[0] = 32'h0F0F_F0F0;
        rsv_sel    = 5'd23;
        rd_sel     = {5'd21, 5'd20};
        #1;
        n_checks++;
        if (bus_n.rd_data[0] !== 32'hA5A5_5A5A || bus_n.busy_vec !== 32'h0020_0000) begin
            n_fail++;
            $display("FAIL midrst_setup: got %h/%h expected a5a55a5a/00200000", bus_n.rd_data[0], bus_n.busy_vec);
        end
        n_rst = 1'b0;
        #1;
        n_checks += 2;
        if (bus_b.rd_data[0] !== '0 || bus_n.rd_data[0] !== '0) begin
            n_fail++;
            $display("FAIL midrst_data_cleared: got %h/%h expected 0", bus_b.rd_data[0], bus_n.rd_data[0]);
        end
        if (bus_b.busy_vec !== '0 || bus_n.rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_busy_cleared: got %h/%b expected 0", bus_b.busy_vec, bus_n.rd_busy);
        end
        @(posedge clk);
        @(negedge clk);
        idle();
        n_rst  = 1'b1;
        rd_sel = {5'd23, 5'd22};
        next_cycle();
        n_checks++;
        if (bus_n.rd_data[0] !== '0 || bus_n.busy_vec !== '0) begin
            n_fail++;
            $display("FAIL midrst_pending_dropped: got %h/%h expected 0", bus_n.rd_data[0], bus_n.busy_vec);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NWR; i++) begin
                wr_en[i]   = ($urandom_range(0, 2) == 0);
                wr_sel[i]  = rand_sel();
                wr_data[i] = $urandom;
            end
            rsv_en  = ($urandom_range(0, 1) == 1);
            rsv_sel = rand_sel();
            flush   = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NRD; k++) rd_sel[k] = rand_sel();
            #1;
            for (int k = 0; k < NRD; k++) begin
                n_checks += 4;
                if (bus_b.rd_data[k] !== m_rd(1'b1, rd_sel[k])) begin
                    n_fail++;
                    $display("FAIL rand_byp_rd_data c%0d p%0d x%0d: got %h expected %h", c, k, rd_sel[k], bus_b.rd_data[k], m_rd(1'b1, rd_sel[k]));
                end
                if (bus_n.rd_data[k] !== m_rd(1'b0, rd_sel[k])) begin
                    n_fail++;
                    $display("FAIL rand_nob_rd_data c%0d p%0d x%0d: got %h expected %h", c, k, rd_sel[k], bus_n.rd_data[k], m_rd(1'b0, rd_sel[k]));
                end
                if (bus_b.rd_busy[k] !== m_rdbusy(1'b1, rd_sel[k])) begin
                    n_fail++;
                    $display("FAIL rand_byp_rd_busy c%0d p%0d x%0d: got %b expected %b", c, k, rd_sel[k], bus_b.rd_busy[k], m_rdbusy(1'b1, rd_sel[k]));
                end
                if (bus_n.rd_busy[k] !== m_rdbusy(1'b0, rd_sel[k])) begin
                    n_fail++;
                    $display("FAIL rand_nob_rd_busy c%0d p%0d x%0d: got %b expected %b", c, k, rd_sel[k], bus_n.rd_busy[k], m_rdbusy(1'b0, rd_sel[k]));
                end
            end
            n_checks++;
            if (bus_b.busy_vec !== m_busy || bus_n.busy_vec !== m_busy) begin
                n_fail++;
                $display("FAIL rand_busy_vec c%0d: got %h/%h expected %h", c, bus_b.busy_vec, bus_n.busy_vec, m_busy);
            end
            next_cycle();
        end
        idle();
    endtask

    initial begin
        idle();
        rd_sel = '0;
        test_reset();
        test_x0();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dyt_regfile_mp.md
# dyt_regfile_mp

Parametrised multi-port integer register file with an integrated register scoreboard for the dyt RISC-V core. It supports N read ports, M write ports and an optional same-cycle write-to-read bypass. The scoreboard holds busy (pending-writeback) bits that decode uses to detect RAW hazards. It replaces the fixed 2R/1W register file and sits between decode (read, reserve) and writeback (write, release).

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of architectural registers; 16 selects RV32E. Must be a power of two, ≥2.
- NRD, 2: number of read ports.
- NWR, 1: number of write ports (1–4).
- BYPASS, 1: 1 = a same-cycle write is forwarded to reads; 0 = a write is readable the next cycle.
- AW (localparam) = $clog2(NREGS).

- clk  in  1  clock, rising edge.
- n_rst  in  1  reset; asynchronous, active-low.
- rd_sel  in  NRD×AW  read address per port.
- rd_data  out  NRD×XLEN  read data per port (combinational).
- rd_busy  out  NRD  1 = the read register has an outstanding writeback (hazard).
- wr_en  in  NWR  write enable per port.
- wr_sel  in  NWR×AW  write address per port.
- wr_data  in  NWR×XLEN  write data per port.
- rsv_en  in  1  reserve (set busy) for rsv_sel; asserted by decode at issue.
- rsv_sel  in  AW  register to reserve.
- flush  in  1  clears all busy bits (pipeline flush).
- busy_vec  out  NREGS  registered busy bits; bit 0 is always 0.

## Operation
- Storage: NREGS×XLEN flops. Register x0 is not stored; reads of x0 return 0. Writes, reservations and busy for x0 are ignored.
- Write: on a clk edge, reg[wr_sel[i]] ← wr_data[i] for each wr_en[i].
  - When several ports hit the same address, the highest port index wins.
- Read, BYPASS=0: rd_data[k] = reg[rd_sel[k]].
- Read, BYPASS=1: when any enabled write port matches rd_sel[k] (≠0), rd_data[k] = wr_data of the highest matching port. Otherwise the stored value is returned.
- Busy set: rsv_en with rsv_sel≠0 sets busy[rsv_sel] at the edge.
- Busy clear: each wr_en[i] with wr_sel[i]≠0 clears busy[wr_sel[i]] at the edge.
- Set and clear of the same register in the same cycle: the set wins (a new producer has issued), so busy stays 1.
- flush: clears every busy bit at the edge. flush overrides rsv_en in that cycle. Writes in the flush cycle still update the data.
- rd_busy[k], BYPASS=0: busy[rd_sel[k]].
- rd_busy[k], BYPASS=1: busy[rd_sel[k]] & ~(any enabled write matches rd_sel[k]).
- rd_busy is always 0 for rd_sel=0.
- Out-of-range addresses cannot occur, because NREGS is a power of two.

## Timing
- Reset (n_rst low, asynchronous): all registers 0 and all busy bits 0.
  - Consequently rd_data = 0, rd_busy = 0 and busy_vec = 0 while reset is held.
- Write-to-read latency: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
- Reserve-to-busy latency: 1 cycle. rd_busy does not reflect rsv_en in the same cycle; decode must not read a register it reserves in the same cycle.
- Release latency: busy_vec drops 1 cycle after the write. With BYPASS=1, rd_busy drops in the write cycle itself.
- Reset asserted mid-operation: state is cleared immediately. Writes or reservations pending at that edge are discarded.
- No handshakes: every input is sampled every cycle, and the block never stalls.

## Structure
- Shared package common_types holds:
  - word_t (XLEN=32 logic vector);
  - the reg_sel_t typedef;
  - REG_ZERO = '0.
- The rf typedef is generalised to logic [NREGS-1:0][XLEN-1:0] inside the module.
- Sub-module dyt_rf_scoreboard (NREGS, NWR parameters) owns:
  - the busy flops;
  - the set/clear/flush priority;
  - the busy_vec output.
- The data array and the bypass muxes stay in the top-level module.

## Test plan
- Reset: after n_rst low then high, read x5 on both ports → rd_data=0, rd_busy=0, busy_vec=0.
- x0 protection: write 0xDEADBEEF to x0 with rsv_en/rsv_sel=0 → rd_data(x0)=0 and busy_vec[0]=0 on the next cycle.
- Bypass: BYPASS=1, write 0x12345678 to x3 while reading x3 → rd_data=0x12345678 in the same cycle. BYPASS=0 → the old value this cycle and 0x12345678 the next cycle.
- Write conflict: NWR=2, port0 writes x7=0x1 and port1 writes x7=0x2 in the same cycle → x7 reads 0x2.
- Scoreboard: reserve x9 → busy_vec[9]=1 next cycle. In the same cycle, write x9 and reserve x9 → busy stays 1. Write x9 alone → busy clears next cycle.
- Flush: reserve x4, x6, x8 in consecutive cycles, then flush together with rsv_en on x10 → busy_vec=0 next cycle (x10 not set); data writes issued in the flush cycle are retained.
